// File: rtl/imem_boot.sv
// imem_boot: instruction RAM with a byte-stream boot loader that holds the CPU in reset until a program is loaded.
// Define IMEM_CHECKSUM_EN to treat the last byte as a checksum over the data bytes.
module imem_boot #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_req_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    input  logic [ADDR_W-1:0] imem_addr_i,
    output logic [DATA_W-1:0] imem_data_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              load_err_o,
    output logic [ADDR_W:0]   prog_len_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              we, hs, full;

    // A boot_req in the same cycle as a handshake wins and the byte is dropped.
    assign hs   = state_q == LOAD && ld_valid_i && !boot_req_i;
    assign full = prog_len_q == DEPTH_L;

`ifdef IMEM_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        prog_len_d = prog_len_q;
        we         = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (boot_req_i) begin
            state_d    = LOAD;
            prog_len_d = '0;
`ifdef IMEM_CHECKSUM_EN
            sum_d      = '0;
`endif
        end else if (hs) begin
`ifdef IMEM_CHECKSUM_EN
            if (ld_last_i)
                state_d = DATA_W'(sum_q + ld_data_i) == '0 ? RUN : ERR;
            else if (full)
                state_d = ERR;
            else begin
                we         = 1'b1;
                prog_len_d = prog_len_q + 1'b1;
                sum_d      = sum_q + ld_data_i;
            end
`else
            if (full)
                state_d = ERR;
            else begin
                we         = 1'b1;
                prog_len_d = prog_len_q + 1'b1;
                state_d    = ld_last_i ? RUN : LOAD;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            prog_len_q <= prog_len_d;
        end
    end

    // RAM is deliberately left out of reset so a partial load survives rst.
    always_ff @(posedge clk) begin
        if (we) mem[prog_len_q[AW-1:0]] <= ld_data_i;
    end

    assign imem_data_o = ({1'b0, imem_addr_i} < DEPTH_L) ? mem[imem_addr_i[AW-1:0]] : '0;
    assign ld_ready_o  = state_q == LOAD;
    assign busy_o      = state_q == LOAD;
    assign cpu_rst_o   = state_q != RUN;
    assign load_err_o  = state_q == ERR;
    assign prog_len_o  = prog_len_q;
endmodule

// File: tb/tb_imem_boot.sv
// tb_imem_boot: randomized check of imem_boot at DEPTH=256 and DEPTH=4 against a behavioural model.
module tb_imem_boot;
    localparam int IDLE = 0, LOAD = 1, RUN = 2, ERR = 3;

    logic       clk = 1'b0, rst = 1'b1, boot_req = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [7:0] ld_data = '0, imem_addr = '0;
    logic       ld_ready [2], cpu_rst [2], busy [2], load_err [2];
    logic [7:0] imem_data [2];
    logic [8:0] prog_len [2];

    int         errors = 0, checks = 0;
    int         dep [2] = '{256, 4};
    int         st [2], len [2], sum [2];
    logic [7:0] mm [2][256];
    bit         mv [2][256];

    always #5 clk = ~clk;

    imem_boot #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) u_big (
        .clk(clk), .rst(rst), .boot_req_i(boot_req), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
        .ld_last_i(ld_last), .ld_ready_o(ld_ready[0]), .imem_addr_i(imem_addr), .imem_data_o(imem_data[0]),
        .cpu_rst_o(cpu_rst[0]), .busy_o(busy[0]), .load_err_o(load_err[0]), .prog_len_o(prog_len[0]));

    imem_boot #(.DATA_W(8), .ADDR_W(8), .DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .boot_req_i(boot_req), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
        .ld_last_i(ld_last), .ld_ready_o(ld_ready[1]), .imem_addr_i(imem_addr), .imem_data_o(imem_data[1]),
        .cpu_rst_o(cpu_rst[1]), .busy_o(busy[1]), .load_err_o(load_err[1]), .prog_len_o(prog_len[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            st[i]  = IDLE;
            len[i] = 0;
            sum[i] = 0;
        end
    endtask

    task automatic model_edge(input bit bq, input bit v, input logic [7:0] d, input bit l);
        for (int i = 0; i < 2; i++) begin
            if (bq) begin
                st[i]  = LOAD;
                len[i] = 0;
                sum[i] = 0;
            end else if (st[i] == LOAD && v) begin
`ifdef IMEM_CHECKSUM_EN
                if (l) st[i] = ((sum[i] + d) % 256 == 0) ? RUN : ERR;
                else if (len[i] == dep[i]) st[i] = ERR;
                else begin
                    mm[i][len[i]] = d;
                    mv[i][len[i]] = 1'b1;
                    len[i]++;
                    sum[i] = (sum[i] + d) % 256;
                end
`else
                if (len[i] == dep[i]) st[i] = ERR;
                else begin
                    mm[i][len[i]] = d;
                    mv[i][len[i]] = 1'b1;
                    len[i]++;
                    if (l) st[i] = RUN;
                end
`endif
            end
        end
    endtask

    task automatic check_out(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s[%0d].cpu_rst", tag, i), cpu_rst[i], st[i] != RUN);
            check($sformatf("%s[%0d].busy", tag, i), busy[i], st[i] == LOAD);
            check($sformatf("%s[%0d].ld_ready", tag, i), ld_ready[i], st[i] == LOAD);
            check($sformatf("%s[%0d].load_err", tag, i), load_err[i], st[i] == ERR);
            check($sformatf("%s[%0d].prog_len", tag, i), prog_len[i], len[i]);
        end
    endtask

    task automatic check_read(input int addr);
        imem_addr = 8'(addr);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (addr >= dep[i]) check($sformatf("rd_oob[%0d]@%0d", i, addr), imem_data[i], 0);
            else if (mv[i][addr]) check($sformatf("rd[%0d]@%0d", i, addr), imem_data[i], mm[i][addr]);
        end
    endtask

    task automatic step(input bit bq, input bit v, input logic [7:0] d, input bit l);
        boot_req = bq;
        ld_valid = v;
        ld_data  = d;
        ld_last  = l;
        @(posedge clk);
        model_edge(bq, v, d, l);
        #1;
        check_out("step");
        check_read(($urandom % 2) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255)));
    endtask

    task automatic send(input logic [7:0] d, input bit l);
        step(1'b0, 1'b1, d, l);
    endtask

    task automatic boot();
        step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         s;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_out("reset");

        boot();
        send(8'h01, 0); send(8'hAE, 0); send(8'h02, 0); send(8'h10, 1);
`ifndef IMEM_CHECKSUM_EN
        check("basic.prog_len", prog_len[0], 4);
        check("basic.cpu_rst", cpu_rst[0], 0);
        step(0, 0, 0, 0);
        imem_addr = 8'd1;
        #1 check("basic.rd1", imem_data[0], 8'hAE);
        imem_addr = 8'd3;
        #1 check("basic.rd3", imem_data[0], 8'h10);
`else
        boot();
        send(8'h01, 0); send(8'hAE, 0); send(8'h51, 1);
        check("chk_ok.cpu_rst", cpu_rst[0], 0);
        check("chk_ok.prog_len", prog_len[0], 2);
        boot();
        send(8'h01, 0); send(8'hAE, 0); send(8'h50, 1);
        check("chk_bad.load_err", load_err[0], 1);
        check("chk_bad.cpu_rst", cpu_rst[0], 1);
`endif

        boot();
        repeat (5) send(8'($urandom), 0);
        check("ovf.load_err", load_err[1], 1);
        check("ovf.prog_len", prog_len[1], 4);
`ifdef IMEM_CHECKSUM_EN
        boot();
        s = 0;
        repeat (4) begin
            b = 8'($urandom);
            s += b;
            send(b, 0);
        end
        send(8'((256 - s % 256) % 256), 1);
        check("full_chk.cpu_rst", cpu_rst[1], 0);
`endif

        boot();
        s = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 8'($urandom), 0);
            b = 8'($urandom);
            s += b;
`ifdef IMEM_CHECKSUM_EN
            if (k == 11) b = 8'((256 - (s - b) % 256) % 256);
`endif
            send(b, k == 11);
        end
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, 0);
            check_read(k);
        end

        check("pre_boot.cpu_rst", cpu_rst[0], 0);
        boot();
        check("boot_run.cpu_rst", cpu_rst[0], 1);
        step(1, 1, 8'h55, 0);
        check("boot_hs.prog_len", prog_len[0], 0);

        repeat (400) begin
            bit bq, v, l;
            bq = $urandom_range(0, 30) == 0;
            v  = $urandom % 2 == 1;
            l  = $urandom_range(0, 12) == 0;
            b  = 8'($urandom);
            if (l && $urandom % 2 == 1) b = 8'((256 - sum[0]) % 256);
            step(bq, v, b, l);
        end

        boot();
        send(8'h12, 0); send(8'h34, 0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_out("async");
        #2 rst = 1'b0;
        boot();
        send(8'hFF, 1);
`ifndef IMEM_CHECKSUM_EN
        check("after_rst.prog_len", prog_len[0], 1);
        imem_addr = 8'd0;
        #1 check("after_rst.mem0", imem_data[0], 8'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
